simple_axi_slave_mem: RTL and testbench

Single-beat AXI4 responder backed by an on-chip 64-bit-wide memory. It is the far end of the `simple_axi_master` bus: it accepts the same reduced channel set (AW/W/B/AR/R with size, strobe and last), performs one read and one write transaction concurrently, and returns OKAY, SLVERR or DECERR. It serves as the bench memory model for the master and as a small scratch RAM on the system interconnect.

---
 rtl/simple_axi_slave_mem.sv | 217 +++++++++++++++++++++
 tb/tb_simple_axi_slave_mem.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_slave_mem.sv
// Single-beat AXI4 responder over a 64-bit on-chip memory. Independent read and
// write FSMs share a dual-port array; errors are decoded per transaction.
module simple_axi_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awsize,

    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic        s_axi_wlast,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,

    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,

    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arsize,

    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        s_axi_rlast,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} r_state_t;

    // Out-of-range beats DECERR first; size, alignment and missing last are SLVERR.
    function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                               input logic [2:0]  size,
                                               input logic        last);
        logic [31:0] off;
        logic [31:0] mask;
        off  = addr - BASE_ADDR;
        mask = (32'd1 << size) - 32'd1;
        if ({1'b0, off} >= MEM_BYTES)
            return RESP_DECERR;
        else if (size > 3'd3)
            return RESP_SLVERR;
        else if ((addr & mask) != 32'd0)
            return RESP_SLVERR;
        else if (!last)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem [DEPTH_WORDS];

    // ---------------- write path ----------------
    w_state_t    w_state;
    logic        aw_held;
    logic        w_held;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        wlast_q;

    logic             aw_take;
    logic             w_take;
    logic             have_aw;
    logic             have_w;
    logic [1:0]       w_resp_c;
    logic [IDX_W-1:0] w_idx;
    logic             mem_we;

    assign aw_take  = s_axi_awvalid && s_axi_awready;
    assign w_take   = s_axi_wvalid && s_axi_wready;
    assign have_aw  = aw_held || aw_take;
    assign have_w   = w_held || w_take;
    assign w_resp_c = decode_resp(aw_addr_q, aw_size_q, wlast_q);
    assign w_idx    = word_index(aw_addr_q);
    assign mem_we   = (w_state == W_EXEC) && (w_resp_c == RESP_OKAY) && !i_rst;

    // NOTE: captured payload registers carry no reset; the held flags alone say
    // whether their contents are meaningful.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_take) begin
                        aw_addr_q <= s_axi_awaddr;
                        aw_size_q <= s_axi_awsize;
                    end
                    if (w_take) begin
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                        wlast_q <= s_axi_wlast;
                    end
                    if (have_aw && have_w) begin
                        w_state       <= W_EXEC;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                    end else begin
                        aw_held       <= have_aw;
                        w_held        <= have_w;
                        s_axi_awready <= !have_aw;
                        s_axi_wready  <= !have_w;
                    end
                end
                W_EXEC: begin
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= w_resp_c;
                    w_state      <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the array is never reset, so contents survive i_rst; this also keeps
    // it mappable onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb_q[i])
                    mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx_q;
    logic [1:0]       r_resp_q;
    logic             ar_take;

    assign ar_take = s_axi_arvalid && s_axi_arready;

    // A fetch colliding with a write to the same word sees the pre-write value,
    // because the array update above lands on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_take) begin
                        r_idx_q       <= word_index(s_axi_araddr);
                        r_resp_q      <= decode_resp(s_axi_araddr, s_axi_arsize, 1'b1);
                        s_axi_arready <= 1'b0;
                        r_state       <= R_FETCH;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    s_axi_rdata  <= (r_resp_q == RESP_OKAY) ? mem[r_idx_q] : 64'd0;
                    s_axi_rresp  <= r_resp_q;
                    s_axi_rvalid <= 1'b1;
                    s_axi_rlast  <= 1'b1;
                    r_state      <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_rlast   <= 1'b0;
                        s_axi_rdata   <= '0;
                        s_axi_rresp   <= RESP_OKAY;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Scoreboard bench for simple_axi_slave_mem: expected B/R responses are queued
// when a transaction is issued and compared when the DUT presents them.
module tb_simple_axi_slave_mem;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 512;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awsize;
    logic        s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arsize;
    logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    simple_axi_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wlast(s_axi_wlast), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rlast(s_axi_rlast),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model [int];
    logic [1:0]  b_q [$];
    r_exp_t      r_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [2:0] size,
                                              input logic last);
        logic [31:0] off;
        off = addr - BASE;
        if (33'(off) >= 33'(DEPTH) * 33'd8) return 2'b11;
        if (size > 3'd3) return 2'b10;
        if ((addr % (32'd1 << size)) != 32'd0) return 2'b10;
        if (!last) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int model_key(input logic [31:0] addr);
        return int'((addr - BASE) >> 3);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [63:0] data,
                               input logic [7:0] strb);
        logic [63:0] w;
        int          k;
        k = model_key(addr);
        w = model.exists(k) ? model[k] : 64'd0;
        for (int i = 0; i < 8; i++)
            if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
        model[k] = w;
    endtask

    task automatic push_read_exp(input logic [31:0] addr, input logic [2:0] size);
        r_exp_t e;
        e.resp = model_resp(addr, size, 1'b1);
        e.data = (e.resp == 2'b00) ? model[model_key(addr)] : 64'd0;
        r_q.push_back(e);
    endtask

    task automatic push_write_exp(input logic [31:0] addr, input logic [2:0] size,
                                  input logic [63:0] data, input logic [7:0] strb,
                                  input logic last);
        logic [1:0] r;
        r = model_resp(addr, size, last);
        b_q.push_back(r);
        if (r == 2'b00) model_write(addr, data, strb);
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [2:0] size,
                               input logic [63:0] data, input logic [7:0] strb,
                               input logic last, input int lead);
        int n = 0;
        @(negedge i_clk);
        while (!(s_axi_awready && s_axi_wready) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("w_ready_wait", 64'(s_axi_awready && s_axi_wready), 64'd1);
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wlast  = last;
        s_axi_wvalid = 1'b1;
        s_axi_awaddr = addr;
        s_axi_awsize = size;
        if (lead == 0) begin
            s_axi_awvalid = 1'b1;
            @(posedge i_clk);
            #1;
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end else begin
            @(posedge i_clk);
            #1;
            s_axi_wvalid = 1'b0;
            repeat (lead) begin
                @(negedge i_clk);
                check("gap_awready", 64'(s_axi_awready), 64'd1);
                check("gap_wready", 64'(s_axi_wready), 64'd0);
            end
            s_axi_awvalid = 1'b1;
            @(posedge i_clk);
            #1;
            s_axi_awvalid = 1'b0;
        end
    endtask

    task automatic drive_read(input logic [31:0] addr, input logic [2:0] size);
        int n = 0;
        @(negedge i_clk);
        while (!s_axi_arready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("ar_ready_wait", 64'(s_axi_arready), 64'd1);
        s_axi_araddr  = addr;
        s_axi_arsize  = size;
        s_axi_arvalid = 1'b1;
        @(posedge i_clk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    // Entered just after the handshake edge; cycle 1 is the first negedge seen.
    task automatic wait_b(input int bp);
        int         lat = 1;
        logic [1:0] exp = 2'b00;
        logic [1:0] seen;
        if (bp > 0) s_axi_bready = 1'b0;
        @(negedge i_clk);
        while (!s_axi_bvalid && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        check("b_latency", 64'(lat), 64'd2);
        if (b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else exp = b_q.pop_front();
        check("bresp", 64'(s_axi_bresp), 64'(exp));
        seen = s_axi_bresp;
        for (int i = 0; i < bp; i++) begin
            @(negedge i_clk);
            check("bp_bvalid", 64'(s_axi_bvalid), 64'd1);
            check("bp_bresp", 64'(s_axi_bresp), 64'(seen));
            check("bp_awready", 64'(s_axi_awready), 64'd0);
        end
        s_axi_bready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("b_done", 64'(s_axi_bvalid), 64'd0);
        check("w_readies_back", 64'({s_axi_awready, s_axi_wready}), 64'd3);
    endtask

    task automatic wait_r(input int bp);
        int          lat = 1;
        r_exp_t      exp = '0;
        logic [63:0] seen;
        if (bp > 0) s_axi_rready = 1'b0;
        @(negedge i_clk);
        while (!s_axi_rvalid && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        check("r_latency", 64'(lat), 64'd2);
        if (r_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
        else exp = r_q.pop_front();
        check("rdata", s_axi_rdata, exp.data);
        check("rresp", 64'(s_axi_rresp), 64'(exp.resp));
        check("rlast", 64'(s_axi_rlast), 64'd1);
        seen = s_axi_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge i_clk);
            check("bp_rvalid", 64'(s_axi_rvalid), 64'd1);
            check("bp_rdata", s_axi_rdata, seen);
            check("bp_arready", 64'(s_axi_arready), 64'd0);
        end
        s_axi_rready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("r_done", 64'(s_axi_rvalid), 64'd0);
        check("arready_back", 64'(s_axi_arready), 64'd1);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [2:0] size,
                             input logic [63:0] data, input logic [7:0] strb,
                             input logic last, input int lead, input int bp);
        push_write_exp(addr, size, data, strb, last);
        drive_write(addr, size, data, strb, last, lead);
        wait_b(bp);
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [2:0] size, input int bp);
        push_read_exp(addr, size);
        drive_read(addr, size);
        wait_r(bp);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                        s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp}), 64'd0);
        check({tag, "_rdata"}, s_axi_rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] a;
        i_rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awsize = '0;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arsize = '0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;

        // Reset state and ready release
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_all_zero("reset_outputs");
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("readies_after_reset",
              64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);

        // Basic write then read
        write_txn(32'h10, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, 0, 0);
        read_txn(32'h10, 3'd3, 0);

        // W three cycles ahead of AW, low-half strobe
        write_txn(32'h10, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b1, 3, 0);
        read_txn(32'h10, 3'd3, 0);
        check("strobe_merge_model", model[model_key(32'h10)], 64'h1122_3344_AAAA_AAAA);

        // Error responses leave memory untouched
        write_txn(BASE + DEPTH * 8, 3'd3, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1, 0, 0);
        read_txn(BASE + DEPTH * 8, 3'd3, 0);
        write_txn(32'h12, 3'd3, 64'hDEAD_BEEF_0000_0002, 8'hFF, 1'b1, 0, 0);
        read_txn(32'h12, 3'd3, 0);
        write_txn(32'h10, 3'd4, 64'hDEAD_BEEF_0000_0003, 8'hFF, 1'b1, 0, 0);
        read_txn(32'h10, 3'd4, 0);
        write_txn(32'h10, 3'd3, 64'hDEAD_BEEF_0000_0004, 8'hFF, 1'b0, 1, 0);
        read_txn(32'h10, 3'd3, 0);

        // Narrow aligned access is accepted
        write_txn(32'h14, 3'd2, 64'h5555_6666_0000_0000, 8'hF0, 1'b1, 0, 0);
        read_txn(32'h10, 3'd3, 0);

        // Backpressure on both response channels
        write_txn(32'h18, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 0, 5);
        read_txn(32'h18, 3'd3, 5);

        // Same-word read and write in the same cycle: read-first
        write_txn(32'h20, 3'd3, 64'hCAFE_0000_0000_0001, 8'hFF, 1'b1, 0, 0);
        push_read_exp(32'h20, 3'd3);
        push_write_exp(32'h20, 3'd3, 64'hBEEF_0000_0000_0002, 8'hFF, 1'b1);
        @(negedge i_clk);
        n = 0;
        while (!(s_axi_awready && s_axi_wready && s_axi_arready) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("concurrent_ready_wait",
              64'(s_axi_awready && s_axi_wready && s_axi_arready), 64'd1);
        s_axi_awaddr = 32'h20; s_axi_awsize = 3'd3; s_axi_awvalid = 1'b1;
        s_axi_wdata = 64'hBEEF_0000_0000_0002; s_axi_wstrb = 8'hFF;
        s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h20; s_axi_arsize = 3'd3; s_axi_arvalid = 1'b1;
        @(posedge i_clk);
        #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        fork
            wait_b(0);
            wait_r(0);
        join
        read_txn(32'h20, 3'd3, 0);

        // Random strobed traffic over a pre-filled window
        for (int i = 0; i < 8; i++)
            write_txn(32'h40 + 32'(8 * i), 3'd3, {$urandom, $urandom}, 8'hFF, 1'b1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            a = 32'h40 + 32'(8 * $urandom_range(0, 7));
            write_txn(a, 3'd3, {$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b1,
                      $urandom_range(0, 2), $urandom_range(0, 2));
            read_txn(a, 3'd3, $urandom_range(0, 2));
        end

        // Reset while a B response is pending; the write itself already landed
        model_write(32'h28, 64'h7777_8888_9999_AAAA, 8'hFF);
        s_axi_bready = 1'b0;
        drive_write(32'h28, 3'd3, 64'h7777_8888_9999_AAAA, 8'hFF, 1'b1, 0);
        n = 0;
        @(negedge i_clk);
        while (!s_axi_bvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("pre_reset_bvalid", 64'(s_axi_bvalid), 64'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check_all_zero("midtxn_reset_outputs");
        i_rst = 1'b0;
        s_axi_bready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        check("readies_after_midtxn_reset",
              64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);
        read_txn(32'h10, 3'd3, 0);
        read_txn(32'h20, 3'd3, 0);
        read_txn(32'h28, 3'd3, 0);

        check("b_queue_drained", 64'(b_q.size()), 64'd0);
        check("r_queue_drained", 64'(r_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
